lsu: RTL and testbench

- Load/store unit: the consumer of the decoded memory-control signals (mem_write, mem_to_reg) and the execute-stage address.
- Accepts one load or store from the core, drives a valid/ready data-memory bus, aligns, masks and sign-extends load data, and returns the result for writeback.
- Holds the pipeline with a stall signal while a transaction is in flight.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/lsu_align.sv | 77 +++++++
 rtl/lsu.sv | 172 +++++++++++++++++
 tb/tb_lsu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the decoder and the load/store unit.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_RESP   = 3'd3,
    ST_FAULT  = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores, load extraction/extension,
// and the alignment/funct3 legality check for an incoming request.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic        req_we,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        req_legal,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] lane_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [3:0]  strb_s;
  logic [31:0] shifted_s;

  // Legal widths per direction plus natural alignment of the address.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      F3_B:    req_legal = 1'b1;
      F3_H:    req_legal = (req_off[0] == 1'b0);
      F3_W:    req_legal = (req_off == 2'b00);
      F3_BU:   req_legal = !req_we;
      F3_HU:   req_legal = !req_we && (req_off[0] == 1'b0);
      default: req_legal = 1'b0;
    endcase
  end

  // Replicate store data across lanes so the strobe alone selects the bytes.
  always_comb begin
    strb_s     = 4'b0000;
    lane_wdata = req_wdata;
    case (req_funct3)
      F3_B: begin
        strb_s     = 4'b0001 << req_off;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        strb_s     = 4'b0011 << req_off;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        strb_s     = 4'b1111;
        lane_wdata = req_wdata;
      end
      default: begin
        strb_s     = 4'b0000;
        lane_wdata = req_wdata;
      end
    endcase
    if (req_we) begin
      lane_wstrb = strb_s;
    end else begin
      lane_wstrb = 4'b0000;
    end
  end

  // Move the addressed bytes to the bottom, then sign- or zero-extend.
  always_comb begin
    shifted_s = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_BU:   ld_data = {24'h000000, shifted_s[7:0]};
      F3_HU:   ld_data = {16'h0000, shifted_s[15:0]};
      F3_W:    ld_data = shifted_s;
      default: ld_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op, runs it on a valid/ready data bus,
// and returns the extended load result with its destination register.
module lsu
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t state_r, state_next_s;

  logic [2:0]        funct3_r;
  logic [1:0]        off_r;
  logic              we_r;
  logic [4:0]        rd_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [3:0]        mem_wstrb_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] resp_rdata_r;

  logic              accept_s;
  logic              legal_s;
  logic [3:0]        lane_wstrb_s;
  logic [31:0]       lane_wdata_s;
  logic [31:0]       ld_data_s;

  assign accept_s = (state_r == ST_IDLE) && req_valid;

  lsu_align u_align (
    .req_funct3 (req_funct3),
    .req_we     (req_we),
    .req_off    (req_addr[1:0]),
    .req_wdata  (req_wdata),
    .req_legal  (legal_s),
    .lane_wstrb (lane_wstrb_s),
    .lane_wdata (lane_wdata_s),
    .ld_funct3  (funct3_r),
    .ld_off     (off_r),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data_s)
  );

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_next_s = legal_s ? ST_REQ : ST_FAULT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_next_s = we_r ? ST_IDLE : ST_WAIT_R;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT_R;
        end
      end
      ST_RESP:  state_next_s = ST_IDLE;
      ST_FAULT: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    fault      = 1'b0;
    stall      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
      end
      ST_REQ: begin
        mem_valid = 1'b1;
        stall     = !(we_r && mem_ready);
      end
      ST_WAIT_R: stall = 1'b1;
      ST_RESP:   resp_valid = 1'b1;
      ST_FAULT:  fault = 1'b1;
      default: begin
        req_ready = 1'b0;
        stall     = 1'b0;
      end
    endcase
  end

  // Request capture at acceptance; bus fields only load for legal requests
  // so the bus stays quiet on a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_r     <= 3'd0;
      off_r        <= 2'd0;
      we_r         <= 1'b0;
      rd_r         <= 5'd0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wstrb_r  <= 4'b0000;
      mem_wdata_r  <= '0;
      resp_rdata_r <= '0;
    end else begin
      if (accept_s) begin
        funct3_r <= req_funct3;
        off_r    <= req_addr[1:0];
        we_r     <= req_we;
        rd_r     <= req_rd;
        if (legal_s) begin
          mem_we_r    <= req_we;
          mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
          mem_wstrb_r <= lane_wstrb_s;
          mem_wdata_r <= lane_wdata_s;
        end
      end
      if ((state_r == ST_WAIT_R) && mem_rvalid) begin
        resp_rdata_r <= ld_data_s;
      end
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wstrb  = mem_wstrb_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_rd    = rd_r;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected bus/response/fault events
// into a queue, and a negedge monitor pops and compares them as they appear.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        fault;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .fault(fault),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: bus transfer (a=addr, b=wdata, strb, we); 1: response (a=rdata, b=rd); 2: fault
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  strb;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push(input int kind, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] strb, input logic we);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.strb = strb; e.we = we;
    exp_q.push_back(e);
  endfunction

  // Monitor: every observed DUT event must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bus", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("bus_kind", e.kind, 0);
          chk("bus_addr", mem_addr, e.a);
          chk("bus_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
          if (e.we) chk("bus_wdata", mem_wdata, e.b);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind", e.kind, 1);
          chk("resp_rdata", resp_rdata, e.a);
          chk("resp_rd", {27'd0, resp_rd}, e.b);
        end
      end
      if (fault) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fault", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fault_kind", e.kind, 2);
        end
      end
    end
  end

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly, input logic exp_fault,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_val);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    #1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_stall", {31'd0, stall}, 32'd1);
    if (exp_fault) begin
      push(2, 32'd0, 32'd0, 4'b0000, 1'b0);
    end else begin
      push(0, exp_addr, exp_val, exp_strb, we);
      if (!we) push(1, exp_val, {27'd0, rd}, 4'b0000, 1'b0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0;
    #1;
    if (exp_fault) begin
      chk("fault_pulse", {31'd0, fault}, 32'd1);
      chk("fault_no_bus", {31'd0, mem_valid}, 32'd0);
      chk("fault_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #2;
      chk("fault_clear", {31'd0, fault}, 32'd0);
      chk("fault_no_bus2", {31'd0, mem_valid}, 32'd0);
      chk("fault_ready", {31'd0, req_ready}, 32'd1);
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        chk("hold_valid", {31'd0, mem_valid}, 32'd1);
        chk("hold_addr", mem_addr, exp_addr);
        chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
        chk("hold_stall", {31'd0, stall}, 32'd1);
        if (we) chk("hold_wdata", mem_wdata, exp_val);
        @(posedge clk); #2;
      end
      mem_ready = 1'b1;
      #1;
      chk("req_valid_hi", {31'd0, mem_valid}, 32'd1);
      chk("req_stall", {31'd0, stall}, {31'd0, ~we});
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #1;
      chk("bus_drop", {31'd0, mem_valid}, 32'd0);
      if (we) begin
        chk("store_done_ready", {31'd0, req_ready}, 32'd1);
        chk("store_no_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        for (int i = 0; i < rv_dly; i++) begin
          chk("wait_stall", {31'd0, stall}, 32'd1);
          chk("wait_no_resp", {31'd0, resp_valid}, 32'd0);
          @(posedge clk); #2;
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_5A5A;
        #1;
        chk("resp_pulse", {31'd0, resp_valid}, 32'd1);
        chk("resp_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        chk("resp_single", {31'd0, resp_valid}, 32'd0);
        chk("resp_ready", {31'd0, req_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Stores: SW, SB (delayed ready), SH upper half.
    run_op(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 0, 1'b0,
           32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    run_op(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 5'd0, 32'h0, 2, 0, 1'b0,
           32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    run_op(1'b1, 3'd1, 32'h0000_0102, 32'h1234_BEEF, 5'd0, 32'h0, 0, 0, 1'b0,
           32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);

    // Loads with extension.
    run_op(1'b0, 3'd0, 32'h0000_0102, 32'h0, 5'd7, 32'h0080_0000, 0, 0, 1'b0,
           32'h0000_0100, 4'b0000, 32'hFFFF_FF80);
    run_op(1'b0, 3'd4, 32'h0000_0102, 32'h0, 5'd8, 32'h0080_0000, 0, 0, 1'b0,
           32'h0000_0100, 4'b0000, 32'h0000_0080);
    run_op(1'b0, 3'd1, 32'h0000_0102, 32'h0, 5'd3, 32'h8001_0000, 0, 0, 1'b0,
           32'h0000_0100, 4'b0000, 32'hFFFF_8001);
    run_op(1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd4, 32'h8001_0000, 0, 0, 1'b0,
           32'h0000_0100, 4'b0000, 32'h0000_8001);
    run_op(1'b0, 3'd0, 32'h0000_0101, 32'h0, 5'd10, 32'h0000_7F00, 0, 0, 1'b0,
           32'h0000_0100, 4'b0000, 32'h0000_007F);
    run_op(1'b0, 3'd0, 32'h0000_0107, 32'h0, 5'd11, 32'h9A00_0000, 0, 0, 1'b0,
           32'h0000_0104, 4'b0000, 32'hFFFF_FF9A);
    run_op(1'b0, 3'd2, 32'h0000_0200, 32'h0, 5'd31, 32'h1234_5678, 3, 2, 1'b0,
           32'h0000_0200, 4'b0000, 32'h1234_5678);

    // Illegal accesses.
    run_op(1'b0, 3'd1, 32'h0000_0101, 32'h0, 5'd1, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    run_op(1'b1, 3'd2, 32'h0000_0102, 32'h1111_1111, 5'd0, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    run_op(1'b0, 3'd3, 32'h0000_0100, 32'h0, 5'd2, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    run_op(1'b1, 3'd4, 32'h0000_0100, 32'h2222_2222, 5'd0, 32'h0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);

    // Reset while waiting for read data, then a stray rvalid in IDLE.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0300; req_rd = 5'd5;
    push(0, 32'h0000_0300, 32'h0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("rst_wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    #1;
    chk("stray_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("stray_no_bus", {31'd0, mem_valid}, 32'd0);

    run_op(1'b0, 3'd2, 32'h0000_0304, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 0, 1'b0,
           32'h0000_0304, 4'b0000, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
